// File: rtl/seg7_scan_driver_pkg.sv
// rtl/seg7_scan_driver_pkg.sv - shared types, segment constants and hex font for the 7-segment scan driver
// Contents:
//   font_t     7-bit active-high a..g pattern, bit 0 = a, bit 6 = g
//   seg_t      8-bit segment bus, bit 7 = decimal point
//   SEG_DP_BIT index of the decimal point in seg_t
//   SEG_NONE   active-high "nothing lit" pattern
//   hex_font() nibble -> standard hex glyph 0-F, active-high gfedcba
package seg7_scan_driver_pkg;

    typedef logic [6:0] font_t;
    typedef logic [7:0] seg_t;

    localparam int   SEG_DP_BIT = 7;
    localparam seg_t SEG_NONE   = 8'h00;

    function automatic font_t hex_font(input logic [3:0] nibble);
        font_t pattern;
        case (nibble)
            4'h0:    pattern = 7'h3F;
            4'h1:    pattern = 7'h06;
            4'h2:    pattern = 7'h5B;
            4'h3:    pattern = 7'h4F;
            4'h4:    pattern = 7'h66;
            4'h5:    pattern = 7'h6D;
            4'h6:    pattern = 7'h7D;
            4'h7:    pattern = 7'h07;
            4'h8:    pattern = 7'h7F;
            4'h9:    pattern = 7'h6F;
            4'hA:    pattern = 7'h77;
            4'hB:    pattern = 7'h7C;
            4'hC:    pattern = 7'h39;
            4'hD:    pattern = 7'h5E;
            4'hE:    pattern = 7'h79;
            default: pattern = 7'h71;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - display value/control inputs and segment/digit pin outputs of the scan driver
// Signals:
//   value[4*N_DIG]  hex nibbles, digit 0 = value[3:0]
//   dp[N_DIG]       decimal point per digit, 1 = lit
//   lzb_en          leading-zero blanking enable
//   enable          0 forces all digits off
//   brightness[4]   duty level 0..15 (used only when the driver is built with dimming)
//   segs[8]         segment pins, [7] = dp
//   digs[N_DIG]     digit enable pins
//   frame_strobe    1-cycle pulse at each frame start
// Modports: master = value source / pin observer, slave = the driver.
interface seg7_scan_driver_if #(
    parameter int N_DIG = 4
);
    logic [4*N_DIG-1:0] value;
    logic [N_DIG-1:0]   dp;
    logic               lzb_en;
    logic               enable;
    logic [3:0]         brightness;
    logic [7:0]         segs;
    logic [N_DIG-1:0]   digs;
    logic               frame_strobe;

    modport master (
        output value, dp, lzb_en, enable, brightness,
        input  segs, digs, frame_strobe
    );

    modport slave (
        input  value, dp, lzb_en, enable, brightness,
        output segs, digs, frame_strobe
    );
endinterface

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational nibble to 7-segment active-high pattern decoder
// Ports:
//   nibble_i   in  4  hex digit
//   pattern_o  out 7  active-high a..g, bit 0 = a
module seg7_hex_decode
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] nibble_i,
    output font_t      pattern_o
);

    assign pattern_o = hex_font(nibble_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed N-digit 7-segment driver with frame snapshots, LZB, dead time and optional dimming
// Optional feature macro: SEG7_DIMMING_EN (PWM dimming from the brightness input).
// Ports:
//   MASTER_CLK  in  1  system clock
//   RST         in  1  asynchronous reset, active-high
//   bus         slave modport of seg7_scan_driver_if: value/dp/lzb_en/enable/brightness in,
//               segs/digs/frame_strobe out (all outputs registered)
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int N_DIG       = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int BLANK_CYC   = 500,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit DIG_ACT_LOW = 1'b1
) (
    input  logic             MASTER_CLK,
    input  logic             RST,
    seg7_scan_driver_if.slave bus
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam seg_t             SEG_OFF = {8{SEG_ACT_LOW}};
    localparam logic [N_DIG-1:0] DIG_OFF = {N_DIG{DIG_ACT_LOW}};

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [4*N_DIG-1:0] snap_value_q, snap_value_d;
    logic [N_DIG-1:0]   snap_dp_q, snap_dp_d;
    logic               snap_lzb_q, snap_lzb_d;
    logic               strobe_q;
    seg_t               segs_q, segs_d;
    logic [N_DIG-1:0]   digs_q, digs_d;

    logic               frame_start;
    logic               cnt_wrap;
    logic               dim_ok;
    logic [3:0]         nibble;
    font_t              font;
    logic               blank;
    logic               active;
    logic [N_DIG-1:0]   dig_hot;
    seg_t               seg_pattern;

    // Slot/digit counters and frame-coherent snapshot. The _d snapshot is used
    // for decoding so the first slot of a frame already shows the new inputs.
    always_comb begin
        frame_start  = (cnt_q == '0) && (idx_q == '0);
        cnt_wrap     = (cnt_q == CNT_W'(SCAN_DIV - 1));
        cnt_d        = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == IDX_W'(N_DIG - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        snap_value_d = frame_start ? bus.value  : snap_value_q;
        snap_dp_d    = frame_start ? bus.dp     : snap_dp_q;
        snap_lzb_d   = frame_start ? bus.lzb_en : snap_lzb_q;
    end

`ifdef SEG7_DIMMING_EN
    // The slot is cut into 16 equal sub-phases; a sub-phase counter avoids a
    // divider on cnt for non-power-of-two SCAN_DIV.
    localparam int SUB_DIV = SCAN_DIV / 16;
    localparam int SUB_W   = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;

    logic [SUB_W-1:0] sub_q, sub_d;
    logic [3:0]       phase_q, phase_d;
    logic [3:0]       snap_bright_q, snap_bright_d;

    always_comb begin
        snap_bright_d = frame_start ? bus.brightness : snap_bright_q;
        sub_d         = sub_q;
        phase_d       = phase_q;
        if (cnt_wrap) begin
            sub_d   = '0;
            phase_d = '0;
        end else if (sub_q == SUB_W'(SUB_DIV - 1)) begin
            sub_d   = '0;
            phase_d = phase_q + 4'd1;
        end else begin
            sub_d   = sub_q + SUB_W'(1);
        end
        dim_ok = (phase_q <= snap_bright_d);
    end

    always_ff @(posedge MASTER_CLK or posedge RST) begin
        if (RST) begin
            sub_q         <= '0;
            phase_q       <= '0;
            snap_bright_q <= '0;
        end else begin
            sub_q         <= sub_d;
            phase_q       <= phase_d;
            snap_bright_q <= snap_bright_d;
        end
    end
`else
    logic unused_brightness;
    assign unused_brightness = ^bus.brightness;
    assign dim_ok            = 1'b1;
`endif

    always_comb begin
        nibble = snap_value_d[4*int'(idx_q) +: 4];
    end

    seg7_hex_decode u_hex_decode (
        .nibble_i  (nibble),
        .pattern_o (font)
    );

    // A digit above 0 is blanked when it and every more significant nibble is
    // zero; its decimal point still shows.
    always_comb begin
        blank  = snap_lzb_d && (idx_q != '0)
                 && ((snap_value_d >> (4*int'(idx_q))) == '0);
        active = bus.enable && (int'(cnt_q) >= BLANK_CYC) && dim_ok;
        for (int k = 0; k < N_DIG; k++) begin
            dig_hot[k] = (int'(idx_q) == k);
        end
        seg_pattern = SEG_NONE;
        if (active) begin
            seg_pattern = {snap_dp_d[idx_q], blank ? 7'h00 : font};
        end
        segs_d = seg_pattern ^ SEG_OFF;
        digs_d = (active ? dig_hot : '0) ^ DIG_OFF;
    end

    always_ff @(posedge MASTER_CLK or posedge RST) begin
        if (RST) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            snap_value_q <= '0;
            snap_dp_q    <= '0;
            snap_lzb_q   <= 1'b0;
            strobe_q     <= 1'b0;
            segs_q       <= SEG_OFF;
            digs_q       <= DIG_OFF;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_value_q <= snap_value_d;
            snap_dp_q    <= snap_dp_d;
            snap_lzb_q   <= snap_lzb_d;
            strobe_q     <= frame_start;
            segs_q       <= segs_d;
            digs_q       <= digs_d;
        end
    end

    assign bus.segs         = segs_q;
    assign bus.digs         = digs_q;
    assign bus.frame_strobe = strobe_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver (4 digits, active-low, 2 dead cycles)
module tb_seg7_scan_driver;

`ifdef SEG7_DIMMING_EN
    localparam int SDIV    = 32;
    localparam int DIM3_ON = 6;
`else
    localparam int SDIV    = 16;
    localparam int DIM3_ON = SDIV - 2;
`endif
    localparam int BLANK = 2;
    localparam int FRAME = 4 * SDIV;
    localparam int LIMIT = 3 * FRAME;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    seg7_scan_driver_if #(.N_DIG(4)) bus_if ();

    seg7_scan_driver #(
        .N_DIG       (4),
        .SCAN_DIV    (SDIV),
        .BLANK_CYC   (BLANK),
        .SEG_ACT_LOW (1'b1),
        .DIG_ACT_LOW (1'b1)
    ) dut (
        .MASTER_CLK (clk),
        .RST        (rst),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dp;
        logic            lzb;
        logic [3:0][7:0] segs;   // expected pins, [3] = digit 3 .. [0] = digit 0
    } vec_t;

    typedef struct {
        logic [3:0] digs;
        logic [7:0] segs;
    } exp_t;

    vec_t vecs [8];
    exp_t sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: no event within %0d cycles", name, LIMIT);
    endtask

    task automatic wait_strobe(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_if.frame_strobe !== 1'b1 && n < LIMIT);
        if (bus_if.frame_strobe !== 1'b1) timeout({name, "_strobe"});
    endtask

    task automatic wait_digit(input string name, input logic want_on);
        int   n = 0;
        logic on;
        do begin
            @(negedge clk);
            n++;
            on = (bus_if.digs !== 4'hF);
        end while (on != want_on && n < LIMIT);
        if (on != want_on) timeout({name, want_on ? "_digon" : "_digoff"});
    endtask

    task automatic check_frame(input string name);
        exp_t e;
        for (int d = 0; d < 4; d++) begin
            wait_digit(name, 1'b1);
            if (sb.size() == 0) begin
                timeout({name, "_sb_empty"});
            end else begin
                e = sb.pop_front();
                check($sformatf("%s_d%0d_digs", name, d), 32'(bus_if.digs), 32'(e.digs));
                check($sformatf("%s_d%0d_segs", name, d), 32'(bus_if.segs), 32'(e.segs));
            end
            wait_digit(name, 1'b0);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        exp_t       e;
        logic [3:0] one_hot;
        bus_if.value  = v.value;
        bus_if.dp     = v.dp;
        bus_if.lzb_en = v.lzb;
        wait_strobe(name);
        for (int d = 0; d < 4; d++) begin
            one_hot = 4'b0001 << d;
            e.digs  = ~one_hot;
            e.segs  = v.segs[d];
            sb.push_back(e);
        end
        check_frame(name);
    endtask

    task automatic measure_duty(input logic [3:0] br, input int exp_on, input string name);
        int c0 = 0;
        int c3 = 0;
        bus_if.brightness = br;
        wait_strobe(name);
        for (int k = 0; k < FRAME; k++) begin
            if (bus_if.digs === 4'b1110) c0++;
            if (bus_if.digs === 4'b0111) c3++;
            @(negedge clk);
        end
        check({name, "_d0_on"}, 32'(c0), 32'(exp_on));
        check({name, "_d3_on"}, 32'(c3), 32'(exp_on));
    endtask

    initial begin
        int n;
        int lit;
        int strobes;

        vecs[0] = '{16'h12AF, 4'b0000, 1'b0, {8'hF9, 8'hA4, 8'h88, 8'h8E}};
        vecs[1] = '{16'h0030, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hB0, 8'hC0}};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
        vecs[3] = '{16'h0000, 4'b0100, 1'b1, {8'hFF, 8'h7F, 8'hFF, 8'hC0}};
        vecs[4] = '{16'h0000, 4'b0000, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hC0}};
        vecs[5] = '{16'h1111, 4'b1001, 1'b0, {8'h79, 8'hF9, 8'hF9, 8'h79}};
        vecs[6] = '{16'h89B0, 4'b0000, 1'b1, {8'h80, 8'h90, 8'h83, 8'hC0}};
        vecs[7] = '{16'h0E0D, 4'b0000, 1'b1, {8'hFF, 8'h86, 8'hC0, 8'hA1}};

        bus_if.value      = 16'h12AF;
        bus_if.dp         = 4'b0000;
        bus_if.lzb_en     = 1'b0;
        bus_if.enable     = 1'b1;
        bus_if.brightness = 4'hF;

        // reset state and first frame after release
        repeat (3) @(negedge clk);
        check("rst_segs", 32'(bus_if.segs), 32'hFF);
        check("rst_digs", 32'(bus_if.digs), 32'hF);
        check("rst_strobe", 32'(bus_if.frame_strobe), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_strobe", 32'(bus_if.frame_strobe), 32'h1);
        @(negedge clk);
        check("rel_strobe_drop", 32'(bus_if.frame_strobe), 32'h0);
        check("rel_dead_digs", 32'(bus_if.digs), 32'hF);
        @(negedge clk);
        check("rel_d0_digs", 32'(bus_if.digs), 32'hE);
        check("rel_d0_segs", 32'(bus_if.segs), 32'h8E);

        // table-driven vectors
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // mid-frame value change is held until the next frame start
        bus_if.value  = 16'h1111;
        bus_if.dp     = 4'b0000;
        bus_if.lzb_en = 1'b0;
        wait_strobe("mid");
        wait_digit("mid", 1'b1);
        check("mid_d0_old", 32'(bus_if.segs), 32'hF9);
        bus_if.value = 16'h2222;
        for (int d = 1; d < 4; d++) begin
            wait_digit("mid", 1'b0);
            wait_digit("mid", 1'b1);
            check($sformatf("mid_d%0d_old", d), 32'(bus_if.segs), 32'hF9);
        end
        wait_strobe("mid_next");
        wait_digit("mid_next", 1'b1);
        check("mid_d0_new", 32'(bus_if.segs), 32'hA4);

        // frame period
        wait_strobe("period");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_if.frame_strobe !== 1'b1 && n < LIMIT);
        check("frame_period", 32'(n), 32'(FRAME));

        // enable=0: digits dark, strobe keeps running
        bus_if.enable = 1'b0;
        lit     = 0;
        strobes = 0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            if (bus_if.digs !== 4'hF) lit++;
            if (bus_if.frame_strobe === 1'b1) strobes++;
        end
        check("disable_lit", 32'(lit), 32'h0);
        check("disable_strobes", 32'(strobes), 32'h1);
        bus_if.enable = 1'b1;

        // duty per slot
        measure_duty(4'hF, SDIV - BLANK, "duty15");
        measure_duty(4'h3, DIM3_ON, "duty3");
        bus_if.brightness = 4'hF;

        // reset asserted mid-slot forces outputs off at once
        bus_if.value = 16'h12AF;
        wait_strobe("midrst");
        wait_digit("midrst", 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_segs", 32'(bus_if.segs), 32'hFF);
        check("midrst_digs", 32'(bus_if.digs), 32'hF);
        @(negedge clk);
        check("midrst_strobe", 32'(bus_if.frame_strobe), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_rel_strobe", 32'(bus_if.frame_strobe), 32'h1);
        @(negedge clk);
        check("midrst_rel_dead", 32'(bus_if.digs), 32'hF);
        @(negedge clk);
        check("midrst_rel_d0_digs", 32'(bus_if.digs), 32'hE);
        check("midrst_rel_d0_segs", 32'(bus_if.segs), 32'h8E);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
